// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder. Stage 1 registers a symbolic instruction, stage 2
// packs it into a machine word held in the output register, tagged with a byte address.
// Optional feature macro: ENCODER_RANGE_CHECK_EN (immediate range rules, err_range).
module instr_encoder #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              err_illegal,
    output logic              err_range
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_SH = 3'd2;
    localparam logic [2:0] FMT_S  = 3'd3;
    localparam logic [2:0] FMT_B  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_U  = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    logic              s1_full;
    logic [5:0]        s1_op;
    logic [4:0]        s1_rd, s1_rs1, s1_rs2;
    logic [31:0]       s1_imm;
    logic [ADDR_W-1:0] addr_cnt;

    logic [2:0]  fmt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        illegal, range_bad;
    logic [31:0] word;
    logic        s1_drop, s1_moves, in_fire, out_fire;

    // Stage 2 decode: operation index to format, opcode and function fields.
    always_comb begin
        fmt     = FMT_R;
        opc     = OPC_OP;
        f3      = 3'd0;
        f7      = 7'h00;
        illegal = 1'b0;
        case (s1_op)
            6'd0:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0; end
            6'd1:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0; f7 = 7'h20; end
            6'd2:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd4; end
            6'd3:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd6; end
            6'd4:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd7; end
            6'd5:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd1; end
            6'd6:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5; end
            6'd7:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5; f7 = 7'h20; end
            6'd8:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd2; end
            6'd9:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd3; end
            6'd10: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd0; end
            6'd11: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd4; end
            6'd12: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd6; end
            6'd13: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd7; end
            6'd14: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd1; end
            6'd15: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd5; end
            6'd16: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd5; f7 = 7'h20; end
            6'd17: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd2; end
            6'd18: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd3; end
            6'd19: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd0; end
            6'd20: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd1; end
            6'd21: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd2; end
            6'd22: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd4; end
            6'd23: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd5; end
            6'd24: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd0; end
            6'd25: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd1; end
            6'd26: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd2; end
            6'd27: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd0; end
            6'd28: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd1; end
            6'd29: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd4; end
            6'd30: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd5; end
            6'd31: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd6; end
            6'd32: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd7; end
            6'd33: begin fmt = FMT_J;  opc = OPC_JAL; end
            6'd34: begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'd0; end
            6'd35: begin fmt = FMT_U;  opc = OPC_LUI; end
            6'd36: begin fmt = FMT_U;  opc = OPC_AUIPC; end
            default: illegal = 1'b1;
        endcase
    end

    // Stage 2 packing: scatter register fields and immediate bits into the format layout.
    always_comb begin
        case (fmt)
            FMT_R:   word = {f7, s1_rs2, s1_rs1, f3, s1_rd, opc};
            FMT_I:   word = {s1_imm[11:0], s1_rs1, f3, s1_rd, opc};
            FMT_SH:  word = {f7, s1_imm[4:0], s1_rs1, f3, s1_rd, opc};
            FMT_S:   word = {s1_imm[11:5], s1_rs2, s1_rs1, f3, s1_imm[4:0], opc};
            FMT_B:   word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, f3, s1_imm[4:1],
                             s1_imm[11], opc};
            FMT_J:   word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, opc};
            default: word = {s1_imm[31:12], s1_rd, opc};
        endcase
    end

    // Stage 2 range check: a signed field fits when all bits above it equal its sign bit.
    always_comb begin
        range_bad = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: range_bad = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
            FMT_SH:       range_bad = |s1_imm[31:5];
            FMT_B:        range_bad = s1_imm[0] || !(&s1_imm[31:12] || ~|s1_imm[31:12]);
            FMT_J:        range_bad = s1_imm[0] || !(&s1_imm[31:20] || ~|s1_imm[31:20]);
            FMT_U:        range_bad = |s1_imm[11:0];
            default:      range_bad = 1'b0;
        endcase
`endif
    end

    // Handshake: a dropped instruction always leaves stage 1, even behind a stalled output.
    always_comb begin
        s1_drop  = s1_full && (illegal || range_bad);
        s1_moves = s1_full && (!out_valid || out_ready || s1_drop);
        in_ready = !s1_full || s1_moves;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        busy     = s1_full || out_valid;
        out_addr = addr_cnt;
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_full <= 1'b0;
            s1_op   <= '0;
            s1_rd   <= '0;
            s1_rs1  <= '0;
            s1_rs2  <= '0;
            s1_imm  <= '0;
        end else if (in_fire) begin
            s1_full <= 1'b1;
            s1_op   <= in_op;
            s1_rd   <= in_rd;
            s1_rs1  <= in_rs1;
            s1_rs2  <= in_rs2;
            s1_imm  <= in_imm;
        end else if (s1_moves) begin
            s1_full <= 1'b0;
        end
    end

    // Output register: only encodable instructions are written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
        end else if (s1_moves && !s1_drop) begin
            out_valid <= 1'b1;
            out_instr <= word;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Address counter: advance on emitted words, reload only while fully idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
        end else if (out_fire) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
        end else if (addr_load && !busy && !in_fire) begin
            addr_cnt <= addr_in & ~ADDR_W'(3);
        end
    end

    // Sticky illegal-op flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal <= 1'b0;
        end else if (s1_full && illegal) begin
            err_illegal <= 1'b1;
        end
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Sticky range-violation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_range <= 1'b0;
        end else if (s1_full && !illegal && range_bad) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios plus randomized traffic against a scoreboard model
// built from the RV32I field layouts.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        addr_load = 1'b0;
    logic [11:0] addr_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
    logic        busy, err_illegal, err_range;

    int n_checks = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .addr_load(addr_load), .addr_in(addr_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .busy(busy),
        .err_illegal(err_illegal), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoder written from the ISA field layouts.
    function automatic logic [31:0] model_enc(input int op, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] imm);
        int f3_tab[37] = '{0,0,4,6,7,1,5,5,2,3, 0,4,6,7,1,5,5,2,3, 0,1,2,4,5, 0,1,2,
                           0,1,4,5,6,7, 0,0,0,0};
        logic [31:0] opc, f3, f7;
        f3 = f3_tab[op];
        f7 = (op == 1 || op == 7 || op == 16) ? 32'h20 : 32'h0;
        if (op <= 9)       opc = 32'h33;
        else if (op <= 18) opc = 32'h13;
        else if (op <= 23) opc = 32'h03;
        else if (op <= 26) opc = 32'h23;
        else if (op <= 32) opc = 32'h63;
        else if (op == 33) opc = 32'h6F;
        else if (op == 34) opc = 32'h67;
        else if (op == 35) opc = 32'h37;
        else               opc = 32'h17;
        if (op <= 9)
            return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
        if (op >= 14 && op <= 16)
            return (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12)
                   | (rd << 7) | opc;
        if (op <= 23 || op == 34)
            return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
        if (op <= 26)
            return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | opc;
        if (op <= 32)
            return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | opc;
        if (op == 33)
            return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | opc;
        return (imm & 32'hFFFFF000) | (rd << 7) | opc;
    endfunction

    function automatic bit model_in_range(input int op, input logic [31:0] imm);
`ifdef ENCODER_RANGE_CHECK_EN
        int s;
        s = int'(imm);
        if (op <= 9) return 1'b1;
        if (op >= 14 && op <= 16) return s >= 0 && s <= 31;
        if (op <= 26 || op == 34) return s >= -2048 && s <= 2047;
        if (op <= 32) return s >= -4096 && s <= 4094 && (s % 2 == 0);
        if (op == 33) return s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2 == 0);
        return (imm & 32'hFFF) == 0;
`else
        return (op >= 0 && imm === imm);
`endif
    endfunction

    task automatic set_in(input int op, input int rd, input int rs1, input int rs2,
                          input logic [31:0] imm);
        in_valid = 1'b1;
        in_op    = 6'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = imm;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard state for the random phase.
    logic [31:0] exp_q[$];
    logic [11:0] m_addr;
    bit          m_ill, m_rng;
    bit          prev_stall;
    logic [31:0] prev_instr;
    logic [11:0] prev_addr;

    // One cycle of randomized (active) or draining traffic; called at a falling edge.
    task automatic step(input bit active);
        logic        ov, bsy, in_fire, out_fire;
        logic [31:0] oi, e, imm;
        int          op, t;
        ov  = out_valid;
        oi  = out_instr;
        bsy = busy;
        check_eq("addr_track", 32'(out_addr), 32'(m_addr));
        check_eq("err_ill_early", 32'(err_illegal && !m_ill), 32'd0);
        if (prev_stall) begin
            check_eq("stall_valid", 32'(ov), 32'd1);
            check_eq("stall_instr", oi, prev_instr);
            check_eq("stall_addr", 32'(out_addr), 32'(prev_addr));
        end
        if (active) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63))
                                              : int'($urandom_range(0, 36));
            case ($urandom_range(0, 5))
                0: imm = $urandom;
                1: begin t = int'($urandom_range(0, 8191)) - 4096; imm = t; end
                2: begin t = int'($urandom_range(0, 63)) - 16; imm = t; end
                3: imm = $urandom & 32'hFFFFF000;
                4: begin
                    t = int'($urandom_range(0, 8)) - 4;
                    t = t + (($urandom_range(0, 1) == 1) ? (1 << 20) : -(1 << 20));
                    imm = t;
                end
                default: begin
                    t = ($urandom_range(0, 1) == 1) ? 4092 + int'($urandom_range(0, 4))
                                                    : -4098 + int'($urandom_range(0, 4));
                    imm = t;
                end
            endcase
            set_in(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_load = ($urandom_range(0, 15) == 0);
            addr_in   = 12'($urandom);
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            addr_load = 1'b0;
        end
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = ov && out_ready;
        if (out_fire) begin
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("rand_word", oi, e);
            end
            m_addr = m_addr + 12'd4;
        end else if (addr_load && !bsy && !in_fire) begin
            m_addr = addr_in & 12'hFFC;
        end
        if (in_fire) begin
            op = int'(in_op);
            if (op > 36) m_ill = 1'b1;
            else if (!model_in_range(op, in_imm)) m_rng = 1'b1;
            else exp_q.push_back(model_enc(op, 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm));
        end
        prev_stall = ov && !out_ready;
        prev_instr = oi;
        prev_addr  = out_addr;
        @(negedge clk);
    endtask

    int acc;

    initial begin
        // Reset state and single addi latency.
        do_reset();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_addr", 32'(out_addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_errs", {30'd0, err_illegal, err_range}, 32'd0);
        set_in(10, 1, 0, 0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("addi_valid", 32'(out_valid), 32'd1);
        check_eq("addi_word", out_instr, 32'h00500093);
        check_eq("addi_addr", 32'(out_addr), 32'h000);
        @(negedge clk);
        check_eq("addi_done", 32'(out_valid), 32'd0);
        check_eq("addi_addr_inc", 32'(out_addr), 32'h004);

        // sub then srai back-to-back.
        do_reset();
        set_in(1, 3, 1, 2, 32'd0);
        @(negedge clk);
        set_in(16, 5, 6, 0, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("sub_word", out_instr, 32'h402081B3);
        check_eq("sub_addr", 32'(out_addr), 32'h000);
        @(negedge clk);
        check_eq("srai_valid", 32'(out_valid), 32'd1);
        check_eq("srai_word", out_instr, 32'h40335293);
        check_eq("srai_addr", 32'(out_addr), 32'h004);
        @(negedge clk);
        check_eq("bb_idle", 32'(out_valid), 32'd0);

        // Output stall: two in flight, then in_ready drops.
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            set_in(10, acc + 1, 0, 0, 32'(acc + 1));
            #1;
            if (in_ready) acc++;
            if (c >= 2) check_eq("stall_hold", out_instr, 32'h00100093);
            @(negedge clk);
        end
        check_eq("stall_accepted", 32'(acc), 32'd2);
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_addr0", 32'(out_addr), 32'h000);
        out_ready = 1'b1;
        set_in(10, 3, 0, 0, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rel_b_word", out_instr, 32'h00200113);
        check_eq("rel_b_addr", 32'(out_addr), 32'h004);
        @(negedge clk);
        check_eq("rel_c_word", out_instr, 32'h00300193);
        check_eq("rel_c_addr", 32'(out_addr), 32'h008);
        @(negedge clk);
        check_eq("rel_idle", 32'(out_valid), 32'd0);

        // Illegal op is dropped without advancing the address.
        do_reset();
        set_in(40, 1, 2, 3, 32'd7);
        @(negedge clk);
        set_in(10, 1, 0, 0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("ill_flag", 32'(err_illegal), 32'd1);
        check_eq("ill_no_out", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("ill_next_word", out_instr, 32'h00500093);
        check_eq("ill_next_addr", 32'(out_addr), 32'h000);
        check_eq("ill_sticky", 32'(err_illegal), 32'd1);

        // addi with immediate 2048.
        do_reset();
        set_in(10, 0, 0, 0, 32'd2048);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
`ifdef ENCODER_RANGE_CHECK_EN
        check_eq("rng_dropped", 32'(out_valid), 32'd0);
        check_eq("rng_flag", 32'(err_range), 32'd1);
`else
        check_eq("trunc_valid", 32'(out_valid), 32'd1);
        check_eq("trunc_word", out_instr, 32'h80000013);
        check_eq("trunc_no_flag", 32'(err_range), 32'd0);
`endif

        // Address load, wrap, and load ignored while busy.
        do_reset();
        addr_load = 1'b1;
        addr_in   = 12'hFFF;
        @(negedge clk);
        addr_load = 1'b0;
        check_eq("load_addr", 32'(out_addr), 32'hFFC);
        set_in(33, 1, 0, 0, 32'd8);
        @(negedge clk);
        set_in(10, 1, 0, 0, 32'd5);
        @(negedge clk);
        in_valid  = 1'b0;
        addr_load = 1'b1;
        addr_in   = 12'h100;
        check_eq("jal_busy", 32'(busy), 32'd1);
        check_eq("jal_word", out_instr, 32'h008000EF);
        check_eq("jal_addr", 32'(out_addr), 32'hFFC);
        @(negedge clk);
        addr_load = 1'b0;
        check_eq("wrap_word", out_instr, 32'h00500093);
        check_eq("wrap_addr", 32'(out_addr), 32'h000);
        @(negedge clk);
        check_eq("busy_load_ignored", 32'(out_addr), 32'h004);

        // Asynchronous reset discards in-flight work immediately.
        set_in(10, 1, 0, 0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("async_valid", 32'(out_valid), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_addr", 32'(out_addr), 32'd0);

        // Randomized traffic against the scoreboard, then drain.
        do_reset();
        exp_q.delete();
        m_addr = '0;
        m_ill = 1'b0;
        m_rng = 1'b0;
        prev_stall = 1'b0;
        for (int i = 0; i < 3000; i++) step(1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_valid", 32'(out_valid), 32'd0);
        check_eq("drain_busy", 32'(busy), 32'd0);
        check_eq("final_err_ill", 32'(err_illegal), 32'(m_ill));
        check_eq("final_err_rng", 32'(err_range), 32'(m_rng));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
